// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types for the intersection phase scheduler: state codes, lamp codes,
// grant enum and the side/pedestrian arbitration helper.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALL_RED     = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_PED_CROSS   = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    typedef enum logic {
        GRANT_SIDE = 1'b0,
        GRANT_PED  = 1'b1
    } grant_t;

    // A lone request wins outright; a tie goes to whoever was not served last.
    function automatic grant_t pick_grant(input logic side_pend, input logic ped_pend,
                                          input grant_t last_grant);
        grant_t g;
        if (side_pend && ped_pend) begin
            if (last_grant == GRANT_SIDE) g = GRANT_PED;
            else                          g = GRANT_SIDE;
        end else if (ped_pend) begin
            g = GRANT_PED;
        end else begin
            g = GRANT_SIDE;
        end
        return g;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every TICK_DIV clocks;
// clr restarts the count so each phase begins on a fresh tick boundary.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer: main/side/pedestrian lamps with tick-timed phases
// and all-red clearance. Optional emergency preemption via `EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 4,
    parameter int MAIN_MIN = 4,
    parameter int SIDE_T   = 4,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int PED_T    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       emerg_req,
    output logic [1:0] main_street,
    output logic [1:0] side_street,
    output logic       pedestrian_light,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_T - 1);

    state_t           state_reg, state_next;
    state_t           dest_reg, dest_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             side_pend_reg, side_pend_next;
    logic             ped_pend_reg, ped_pend_next;
    grant_t           last_grant_reg, last_grant_next;
    logic             preempt_reg, preempt_next;
    logic             entry_reg;
    logic             tick;
    logic             hold;
    logic             state_change;
    logic             emerg;

`ifdef EMERGENCY_PREEMPT_EN
    assign emerg = emerg_req;
`else
    logic unused_emerg;
    assign unused_emerg = emerg_req;
    assign emerg = 1'b0;
`endif

    assign state_change = (state_next != state_reg);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (state_change || hold),
        .tick (tick)
    );

    // Next-state logic; preempt_reg stops the post-yellow grant from overriding an emergency return.
    always_comb begin
        state_next   = state_reg;
        dest_next    = dest_reg;
        preempt_next = preempt_reg;
        hold         = 1'b0;
        case (state_reg)
            ST_MAIN_GREEN: begin
                if (emerg) begin
                    state_next   = ST_MAIN_YELLOW;
                    dest_next    = ST_MAIN_GREEN;
                    preempt_next = 1'b1;
                end else if (tick && timer_reg == MAIN_LAST && (side_pend_reg || ped_pend_reg)) begin
                    state_next = ST_MAIN_YELLOW;
                end
            end
            ST_MAIN_YELLOW: begin
                if (tick && timer_reg == YELLOW_LAST) begin
                    state_next   = ST_ALL_RED;
                    preempt_next = 1'b0;
                    if (preempt_reg)
                        dest_next = ST_MAIN_GREEN;
                    else if (pick_grant(side_pend_reg, ped_pend_reg, last_grant_reg) == GRANT_PED)
                        dest_next = ST_PED_CROSS;
                    else
                        dest_next = ST_SIDE_GREEN;
                end
            end
            ST_ALL_RED: begin
                if (emerg) begin
                    hold = 1'b1;
                end else if (tick && timer_reg == ALLRED_LAST) begin
                    state_next = dest_reg;
                end
            end
            ST_SIDE_GREEN: begin
                if (emerg) begin
                    state_next = ST_SIDE_YELLOW;
                    dest_next  = ST_MAIN_GREEN;
                end else if (tick && timer_reg == SIDE_LAST) begin
                    state_next = ST_SIDE_YELLOW;
                end
            end
            ST_SIDE_YELLOW: begin
                if (tick && timer_reg == YELLOW_LAST) begin
                    state_next = ST_ALL_RED;
                    dest_next  = ST_MAIN_GREEN;
                end
            end
            ST_PED_CROSS: begin
                if (emerg || (tick && timer_reg == PED_LAST)) begin
                    state_next = ST_ALL_RED;
                    dest_next  = ST_MAIN_GREEN;
                end
            end
            default: begin
                state_next = ST_MAIN_GREEN;
            end
        endcase
    end

    // Timer saturates in MAIN_GREEN so the minimum-green condition stays true while waiting.
    always_comb begin
        timer_next = timer_reg;
        if (state_change || hold) begin
            timer_next = '0;
        end else if (tick) begin
            if (!(state_reg == ST_MAIN_GREEN && timer_reg == MAIN_LAST))
                timer_next = timer_reg + 1'b1;
        end
    end

    always_comb begin
        side_pend_next  = side_pend_reg | side_req;
        ped_pend_next   = ped_pend_reg | ped_req;
        last_grant_next = last_grant_reg;
        if (state_reg == ST_SIDE_GREEN) begin
            side_pend_next  = 1'b0;
            last_grant_next = GRANT_SIDE;
        end
        if (state_reg == ST_PED_CROSS) begin
            ped_pend_next   = 1'b0;
            last_grant_next = GRANT_PED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_MAIN_GREEN;
            dest_reg       <= ST_MAIN_GREEN;
            timer_reg      <= '0;
            side_pend_reg  <= 1'b0;
            ped_pend_reg   <= 1'b0;
            last_grant_reg <= GRANT_PED;
            preempt_reg    <= 1'b0;
            entry_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dest_reg       <= dest_next;
            timer_reg      <= timer_next;
            side_pend_reg  <= side_pend_next;
            ped_pend_reg   <= ped_pend_next;
            last_grant_reg <= last_grant_next;
            preempt_reg    <= preempt_next;
            entry_reg      <= state_change;
        end
    end

    always_comb begin
        main_street      = LAMP_RED;
        side_street      = LAMP_RED;
        pedestrian_light = 1'b0;
        case (state_reg)
            ST_MAIN_GREEN:  main_street      = LAMP_GREEN;
            ST_MAIN_YELLOW: main_street      = LAMP_YELLOW;
            ST_SIDE_GREEN:  side_street      = LAMP_GREEN;
            ST_SIDE_YELLOW: side_street      = LAMP_YELLOW;
            ST_PED_CROSS:   pedestrian_light = 1'b1;
            default: ;
        endcase
    end

    assign ped_ack = entry_reg && (state_reg == ST_PED_CROSS);
    assign phase   = state_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed-scenario bench: the stimulus process queues the expected lamps/phase for
// every cycle, and a negedge monitor pops and compares against the DUT.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg_req = 1'b0;
    logic [1:0] main_street;
    logic [1:0] side_street;
    logic       pedestrian_light;
    logic       ped_ack;
    logic [2:0] phase;

    typedef struct {
        int         test_id;
        int         cyc;
        logic [1:0] main_l;
        logic [1:0] side_l;
        logic       walk;
        logic       ack;
        logic [2:0] ph;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    int   seg_start[0:15];
    int   seg_phase[0:15];
    int   nseg;

    traffic_phase_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .side_req        (side_req),
        .ped_req         (ped_req),
        .emerg_req       (emerg_req),
        .main_street     (main_street),
        .side_street     (side_street),
        .pedestrian_light(pedestrian_light),
        .ped_ack         (ped_ack),
        .phase           (phase)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (main_street !== mon_e.main_l || side_street !== mon_e.side_l ||
                pedestrian_light !== mon_e.walk || ped_ack !== mon_e.ack || phase !== mon_e.ph) begin
                errors++;
                $display("FAIL t%0d_c%0d: got main=%b side=%b walk=%b ack=%b phase=%0d, want main=%b side=%b walk=%b ack=%b phase=%0d",
                         mon_e.test_id, mon_e.cyc, main_street, side_street, pedestrian_light, ped_ack, phase,
                         mon_e.main_l, mon_e.side_l, mon_e.walk, mon_e.ack, mon_e.ph);
            end
        end
    end

    function automatic logic [2:0] phase_at(input int c);
        logic [2:0] ph;
        ph = 3'd0;
        for (int i = 0; i < nseg; i++)
            if (c >= seg_start[i]) ph = 3'(seg_phase[i]);
        return ph;
    endfunction

    function automatic exp_t mk_exp(input int t, input int c, input logic [2:0] ph, input logic ack);
        exp_t e;
        e.test_id = t;
        e.cyc     = c;
        e.ph      = ph;
        e.ack     = ack;
        e.main_l  = 2'b00;
        e.side_l  = 2'b00;
        e.walk    = 1'b0;
        case (ph)
            3'd0: e.main_l = 2'b10;
            3'd1: e.main_l = 2'b01;
            3'd3: e.side_l = 2'b10;
            3'd4: e.side_l = 2'b01;
            3'd5: e.walk   = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Returns {side_req, ped_req, emerg_req} for cycle c of test t.
    function automatic logic [2:0] stim(input int t, input int c);
        logic [2:0] r;
        r = 3'b000;
        case (t)
            2: if (c == 2) r[2] = 1'b1;
            3: if (c == 1) r = 3'b110;
            4: if (c <= 33) r[1] = 1'b1;
            5: begin
                if (c == 2)  r[2] = 1'b1;
                if (c == 20) r[1] = 1'b1;
            end
            6: begin
                if (c == 2) r[2] = 1'b1;
                if (c >= 30 && c <= 60) r[0] = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic set_segs(input int n, input int st[0:15], input int ph[0:15]);
        nseg = n;
        for (int i = 0; i < 16; i++) begin
            seg_start[i] = st[i];
            seg_phase[i] = ph[i];
        end
    endtask

    task automatic run_test(input int t, input int ncyc, input int ack_cycle);
        logic [2:0] s;
        side_req  = 1'b0;
        ped_req   = 1'b0;
        emerg_req = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            s = stim(t, c);
            {side_req, ped_req, emerg_req} = s;
            reset = (t == 5 && c == 30);
            exp_q.push_back(mk_exp(t, c, phase_at(c), (c == ack_cycle)));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int st[0:15];
        int ph[0:15];
        repeat (2) @(posedge clk);
        #1;

        // 1: idle main green
        st = '{default: 0}; ph = '{default: 0};
        set_segs(1, st, ph);
        run_test(1, 200, -1);

        // 2: single side request
        st = '{0, 16, 24, 28, 44, 52, 56, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ph = '{0, 1, 2, 3, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_segs(7, st, ph);
        run_test(2, 100, -1);

        // 3: side and ped tie; side first, ped after a full main-green minimum
        st = '{0, 16, 24, 28, 44, 52, 56, 72, 80, 84, 96, 100, 0, 0, 0, 0};
        ph = '{0, 1, 2, 3, 4, 2, 0, 1, 2, 5, 2, 0, 0, 0, 0, 0};
        set_segs(12, st, ph);
        run_test(3, 130, 84);

        // 4: ped held across the crossing entry; no second crossing
        st = '{0, 16, 24, 28, 40, 44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ph = '{0, 1, 2, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_segs(6, st, ph);
        run_test(4, 100, 28);

        // 5: reset mid side-green with a ped request pending
        st = '{0, 16, 24, 28, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ph = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_segs(5, st, ph);
        run_test(5, 100, -1);

        // 6: emergency during side green
`ifdef EMERGENCY_PREEMPT_EN
        st = '{0, 16, 24, 28, 31, 39, 65, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ph = '{0, 1, 2, 3, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        st = '{0, 16, 24, 28, 44, 52, 56, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ph = '{0, 1, 2, 3, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        set_segs(7, st, ph);
        run_test(6, 100, -1);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
